load_store_unit: RTL and testbench

//  Bridges the processor's data-access request to the byte-enabled, 64x32 synchronous DATA_MEMORY.
//  - Formats stores into lane-aligned data plus byteena.
//  - Extracts and sign/zero-extends loads.
//  - Flags misaligned or illegal accesses.
//  - Sequences the memory's read latency behind a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 8 +
 rtl/lsu_lane_align.sv | 32 +++
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: size codes, FSM state type and MMIO word address shared by the load/store unit
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [5:0] MMIO_WORD_ADDR = 6'h3F;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational store lane replication/byteena, load select/extend, misalign detect
//   op[3:0]   store/unsigned/size request code      lane[1:0]  byte offset within word
//   wdata     right-justified store data            rdata      raw word read back
//   st_data   lane-replicated store data            st_be      byte enables for the store
//   ld_data   selected and extended load data       bad        misaligned or illegal size
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] ld_data,
  output logic        bad
);
  logic [1:0]  sz;
  logic        sx;
  logic [7:0]  b;
  logic [15:0] h;
  assign sz = op[1:0];
  assign sx = ~op[2];
  assign b  = rdata[{lane, 3'b000} +: 8];
  assign h  = rdata[{lane[1], 4'b0000} +: 16];
  always_comb begin
    st_data = sz == SZ_B ? {4{wdata[7:0]}} : sz == SZ_H ? {2{wdata[15:0]}} : wdata;
    st_be   = sz == SZ_B ? 4'b0001 << lane : sz == SZ_H ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    ld_data = sz == SZ_B ? {{24{sx & b[7]}}, b} : sz == SZ_H ? {{16{sx & h[15]}}, h} : rdata;
    bad     = sz == 2'b11 || (sz == SZ_H && lane[0]) || (sz == SZ_W && lane != 2'b00);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: valid/ready load/store front end for a byte-enabled 64x32 synchronous data memory
//   clk, reset (async, active-high)
//   req_valid/req_ready/req_op/req_addr/req_wdata   processor request handshake
//   resp_valid/resp_rdata/resp_err                  registered one-cycle response
//   mem_address/mem_byteena/mem_data/mem_wren/mem_q memory port (outputs registered)
//   mmio_out                                        present only when LSU_MMIO_EN is defined
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] mem_address,
  output logic [3:0]        mem_byteena,
  output logic [31:0]       mem_data,
  output logic              mem_wren,
  input  logic [31:0]       mem_q
`ifdef LSU_MMIO_EN
  ,output logic [31:0]      mmio_out
`endif
);
  lsu_state_t        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic              err_q, err_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       hold_q, hold_d;
  logic [ADDR_W-3:0] mem_address_q, mem_address_d;
  logic [3:0]        mem_byteena_q, mem_byteena_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [ADDR_W-3:0] req_word;
  logic              idle, req_mmio;
  logic [3:0]        al_op;
  logic [1:0]        al_lane;
  logic [31:0]       al_rdata, st_data, ld_data;
  logic [3:0]        st_be;
  logic              bad;
  assign idle      = state_q == IDLE;
  assign req_ready = idle;
  assign req_word  = req_addr[ADDR_W-1:2];
  assign al_op     = idle ? req_op : op_q;
  assign al_lane   = idle ? req_addr[1:0] : lane_q;
  lsu_lane_align u_align (
    .op      (al_op),
    .lane    (al_lane),
    .wdata   (req_wdata),
    .rdata   (al_rdata),
    .st_data (st_data),
    .st_be   (st_be),
    .ld_data (ld_data),
    .bad     (bad)
  );
`ifdef LSU_MMIO_EN
  logic        mmio_sel_q, mmio_sel_d;
  logic [31:0] mmio_out_q, mmio_out_d, be_mask;
  assign req_mmio = req_word == (ADDR_W-2)'(MMIO_WORD_ADDR);
  assign al_rdata = mmio_sel_q ? mmio_out_q : mem_q;
  assign be_mask  = {{8{st_be[3]}}, {8{st_be[2]}}, {8{st_be[1]}}, {8{st_be[0]}}};
  assign mmio_out = mmio_out_q;
  always_comb begin
    mmio_sel_d = idle && req_valid ? req_mmio : mmio_sel_q;
    mmio_out_d = idle && req_valid && req_op[3] && !bad && req_mmio
               ? (mmio_out_q & ~be_mask) | (st_data & be_mask) : mmio_out_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mmio_sel_q <= 1'b0;
      mmio_out_q <= '0;
    end else begin
      mmio_sel_q <= mmio_sel_d;
      mmio_out_q <= mmio_out_d;
    end
  end
`else
  assign req_mmio = 1'b0;
  assign al_rdata = mem_q;
`endif
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    lane_d        = lane_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    mem_address_d = '0;
    mem_byteena_d = '0;
    mem_data_d    = '0;
    mem_wren_d    = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        op_d    = req_op;
        lane_d  = req_addr[1:0];
        err_d   = bad;
        hold_d  = '0;
        state_d = bad ? RESP : ISSUE;
        if (!bad) begin
          mem_address_d = req_word;
          mem_wren_d    = req_op[3] & ~req_mmio;
          mem_byteena_d = mem_wren_d ? st_be : 4'b0000;
          mem_data_d    = mem_wren_d ? st_data : '0;
        end
      end
      ISSUE: begin
        state_d = op_q[3] ? RESP : WAIT;
        cnt_d   = 2'(MEM_LATENCY - 1);
      end
      WAIT: begin
        state_d = cnt_q == 2'd0 ? RESP : WAIT;
        cnt_d   = cnt_q == 2'd0 ? cnt_q : cnt_q - 2'd1;
        hold_d  = cnt_q == 2'd0 ? ld_data : hold_q;
      end
      default: state_d = IDLE;
    endcase
    resp_valid_d = state_q == RESP;
    resp_rdata_d = resp_valid_d ? hold_q : '0;
    resp_err_d   = resp_valid_d & err_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      op_q          <= '0;
      lane_q        <= '0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
      hold_q        <= '0;
      mem_address_q <= '0;
      mem_byteena_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      lane_q        <= lane_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      mem_address_q <= mem_address_d;
      mem_byteena_q <= mem_byteena_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
    end
  end
  assign mem_address = mem_address_q;
  assign mem_byteena = mem_byteena_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus random load/store traffic checked against a byte-level memory model
module tb_load_store_unit;
  localparam int LAT = 3;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [5:0]  mem_address;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_data, mem_q;
  logic        mem_wren;
`ifdef LSU_MMIO_EN
  logic [31:0] mmio_out;
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif
  int errors = 0;
  int checks = 0;
  int be_bad = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] ref_mmio = '0;
  logic [31:0] mem [64];
  logic [31:0] pipe [LAT];
  always #5 clk = ~clk;
  load_store_unit #(.ADDR_W(8), .MEM_LATENCY(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_address (mem_address),
    .mem_byteena (mem_byteena),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
`ifdef LSU_MMIO_EN
    ,.mmio_out   (mmio_out)
`endif
  );
  always @(posedge clk) begin
    if (mem_wren)
      for (int b = 0; b < 4; b++)
        if (mem_byteena[b]) mem[mem_address][8*b +: 8] <= mem_data[8*b +: 8];
    pipe[0] <= mem[mem_address];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_q = pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mmio(input logic [7:0] a);
    return MMIO_EN && a[7:2] == 6'h3F;
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [7:0] a);
    logic [31:0] w = is_mmio(a) ? ref_mmio : ref_mem[a[7:2]];
    int k = int'(a[1:0]);
    int n = op[1:0] == 2'b00 ? 1 : op[1:0] == 2'b01 ? 2 : 4;
    logic [31:0] v = w >> (8 * k);
    if (n < 4) begin
      v = v % (32'd1 << (8 * n));
      if (!op[2] && v >= (32'd1 << (8 * n - 1))) v = v | (32'hFFFF_FFFF << (8 * n));
    end
    return v;
  endfunction

  task automatic txn(input logic [3:0] op, input logic [7:0] a, input logic [31:0] wd, input bit hold);
    int k = int'(a[1:0]);
    int n = op[1:0] == 2'b00 ? 1 : op[1:0] == 2'b01 ? 2 : 4;
    bit err = op[1:0] == 2'b11 || (k % n) != 0;
    bit st = op[3];
    bit wr_exp = st && !err && !is_mmio(a);
    int lat = err ? 1 : st ? 2 : 2 + LAT;
    logic [31:0] exp_rd = (err || st) ? 32'h0 : ref_load(op, a);
    logic [3:0] exp_be = 4'(((1 << n) - 1) << k);
    logic [31:0] exp_data = n == 1 ? wd[7:0] * 32'h0101_0101 : n == 2 ? wd[15:0] * 32'h0001_0001 : wd;
    int wr = 0;
    int rc = -1;
    logic [31:0] rd = '0, wa = '0, wb = '0, wdat = '0, w;
    logic re = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    for (int c = 0; c <= 10 && rc < 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 1) req_valid = 1'b0;
      if (c == 0) chk("req_ready_busy", {31'b0, req_ready}, 0);
      if (mem_wren) begin
        wr++; wa = 32'(mem_address); wb = 32'(mem_byteena); wdat = mem_data;
      end else if (mem_byteena != 4'b0000) be_bad++;
      if (resp_valid) begin
        rc = c; rd = resp_rdata; re = resp_err;
        chk("ready_at_resp", {31'b0, req_ready}, 1);
      end
    end
    chk("resp_latency", rc, lat);
    chk("resp_rdata", rd, exp_rd);
    chk("resp_err", {31'b0, re}, {31'b0, err});
    chk("wren_cycles", wr, {31'b0, wr_exp});
    if (wr_exp) begin
      chk("mem_address", wa, 32'(a[7:2]));
      chk("mem_byteena", wb, 32'(exp_be));
      chk("mem_data", wdat, exp_data);
    end
    if (st && !err) begin
      w = is_mmio(a) ? ref_mmio : ref_mem[a[7:2]];
      for (int i = 0; i < n; i++) w[8*(k+i) +: 8] = wd[8*i +: 8];
      if (is_mmio(a)) ref_mmio = w; else ref_mem[a[7:2]] = w;
    end
  endtask

  initial begin
    int seen;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", {31'b0, resp_err}, 0);
    chk("rst_mem_wren", {31'b0, mem_wren}, 0);
    chk("rst_mem_byteena", 32'(mem_byteena), 0);
    chk("rst_mem_address", 32'(mem_address), 0);
    chk("rst_mem_data", mem_data, 0);
    @(negedge clk); reset = 1'b0;
    for (int w = 0; w < 16; w++) txn(4'b1010, 8'(w * 4), $urandom, 1'b0);
    txn(4'b1010, 8'h10, 32'hDEAD_BEEF, 1'b0);
    txn(4'b1000, 8'h13, 32'h0000_00A5, 1'b0);
    txn(4'b0000, 8'h13, 32'h0, 1'b0);
    txn(4'b0100, 8'h13, 32'h0, 1'b0);
    txn(4'b1010, 8'h10, 32'h8001_BEEF, 1'b0);
    txn(4'b0001, 8'h12, 32'h0, 1'b0);
    txn(4'b0101, 8'h12, 32'h0, 1'b1);
    txn(4'b0010, 8'h11, 32'h0, 1'b0);
    txn(4'b1001, 8'h05, 32'h5555, 1'b1);
    txn(4'b0011, 8'h00, 32'h0, 1'b0);
    txn(4'b1110, 8'h20, 32'h1357_9BDF, 1'b0);
    txn(4'b0110, 8'h20, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b0010; req_addr = 8'h10;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    chk("midrst_req_ready", {31'b0, req_ready}, 1);
    chk("midrst_mem_wren", {31'b0, mem_wren}, 0);
    chk("midrst_resp_valid", {31'b0, resp_valid}, 0);
    @(negedge clk); reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    chk("midrst_no_resp", seen, 0);
    txn(4'b0010, 8'h10, 32'h0, 1'b0);
`ifdef LSU_MMIO_EN
    txn(4'b1001, 8'hFE, 32'h0000_1234, 1'b0);
    chk("mmio_out", mmio_out, 32'h1234_0000);
    txn(4'b0010, 8'hFC, 32'h0, 1'b0);
    txn(4'b1000, 8'hFD, 32'h0000_0077, 1'b0);
    chk("mmio_out_byte", mmio_out, 32'h1234_7700);
    txn(4'b0000, 8'hFD, 32'h0, 1'b0);
`endif
    for (int i = 0; i < 80; i++)
      txn(4'($urandom_range(0, 15)), 8'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)));
    chk("byteena_idle_zero", be_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
